// File: rtl/mux_rr_feeder.sv
// rtl/mux_rr_feeder.sv - round-robin two-channel feeder for the 2:1 data mux
module mux_rr_feeder #(
    parameter int width_size = 2,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in0_valid,
    input  logic [width_size:0]   in0_data,
    output logic                  in0_ready,
    input  logic                  in1_valid,
    input  logic [width_size:0]   in1_data,
    output logic                  in1_ready,
    output logic [width_size:0]   d0,
    output logic [width_size:0]   d1,
    output logic                  sel,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  cnt_clr,
    output logic [CNT_W-1:0]      cnt0,
    output logic [CNT_W-1:0]      cnt1
);

    logic load;
    logic grant;
    logic grant_valid;
    logic last_grant;

    // A tie goes to the channel that did not win last; a lone requester always wins.
    always_comb begin
        load        = !out_valid || out_ready;
        grant_valid = load && !rst && (in0_valid || in1_valid);
        if (in0_valid && in1_valid)
            grant = !last_grant;
        else
            grant = in1_valid;
        in0_ready = grant_valid && !grant;
        in1_ready = grant_valid && grant;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            sel        <= 1'b0;
            d0         <= '0;
            d1         <= '0;
            last_grant <= 1'b1;
        end else if (load) begin
            if (grant_valid) begin
                sel        <= grant;
                last_grant <= grant;
                out_valid  <= 1'b1;
                if (grant)
                    d1 <= in1_data;
                else
                    d0 <= in0_data;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Clear wins over a coincident handshake; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (in0_ready && !(&cnt0))
                cnt0 <= cnt0 + 1'b1;
            if (in1_ready && !(&cnt1))
                cnt1 <= cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_rr_feeder.sv
// tb/tb_mux_rr_feeder.sv - directed self-checking bench for mux_rr_feeder
module tb_mux_rr_feeder;

    localparam int W  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in0_valid, in1_valid, in0_ready, in1_ready;
    logic [W:0]    in0_data, in1_data, d0, d1;
    logic          sel, out_valid, out_ready, cnt_clr;
    logic [CW-1:0] cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    mux_rr_feeder #(.width_size(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
        .d0(d0), .d1(d1), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in0_valid = 1'b1; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        #1;
        chk("rst_in0_ready", in0_ready, 0);
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_d0", d0, 0);
        chk("rst_d1", d1, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_in1_ready", in1_ready, 0);

        // single channel 0 beat
        rst = 1'b0; in0_valid = 1'b1; in0_data = 3'b011; out_ready = 1'b1;
        #1;
        chk("single_in0_ready", in0_ready, 1);
        chk("single_in1_ready", in1_ready, 0);
        step();
        in0_valid = 1'b0; in0_data = 3'b110;
        chk("single_d0", d0, 3'b011);
        chk("single_sel", sel, 0);
        chk("single_out_valid", out_valid, 1);
        chk("single_cnt0", cnt0, 1);

        // idle drain plus counter clear
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("idle_out_valid", out_valid, 0);
        chk("idle_d0_hold", d0, 3'b011);
        chk("clr_cnt0", cnt0, 0);

        // fresh reset so the first tie goes to channel 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        in0_valid = 1'b1; in1_valid = 1'b1; in0_data = 3'b111; in1_data = 3'b100;
        #1;
        chk("tie_first_in0_ready", in0_ready, 1);
        chk("tie_first_in1_ready", in1_ready, 0);
        step(); chk("tie_sel_0", sel, 0); chk("tie_d0", d0, 3'b111);
        step(); chk("tie_sel_1", sel, 1); chk("tie_d1", d1, 3'b100);
        step(); chk("tie_sel_2", sel, 0);
        step(); chk("tie_sel_3", sel, 1);
        chk("tie_cnt0", cnt0, 2);
        chk("tie_cnt1", cnt1, 2);
        chk("tie_out_valid", out_valid, 1);

        // backpressure: hold beat while in1 data wiggles
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in1_data = 3'(i);
            #1;
            chk("bp_in0_ready", in0_ready, 0);
            chk("bp_in1_ready", in1_ready, 0);
            step();
            chk("bp_sel", sel, 1);
            chk("bp_d0", d0, 3'b111);
            chk("bp_d1", d1, 3'b100);
            chk("bp_out_valid", out_valid, 1);
        end
        chk("bp_cnt1", cnt1, 2);
        out_ready = 1'b1; in0_data = 3'b101;
        #1;
        chk("bp_release_in0_ready", in0_ready, 1);
        step();
        chk("bp_release_sel", sel, 0);
        chk("bp_release_d0", d0, 3'b101);
        chk("bp_release_d1", d1, 3'b100);
        chk("bp_release_out_valid", out_valid, 1);
        chk("bp_release_cnt0", cnt0, 3);

        // saturation on channel 1
        in0_valid = 1'b0; in1_valid = 1'b0; cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("sat_pre_cnt1", cnt1, 0);
        in1_valid = 1'b1; in1_data = 3'b001;
        for (int i = 0; i < 5; i++) step();
        chk("sat_cnt1", cnt1, 3);
        chk("sat_cnt0", cnt0, 0);
        in1_data = 3'b010; cnt_clr = 1'b1;
        #1;
        chk("clr_grant_in1_ready", in1_ready, 1);
        step();
        cnt_clr = 1'b0;
        chk("clr_grant_cnt1", cnt1, 0);
        chk("mid_sel", sel, 1);
        chk("mid_d1", d1, 3'b010);
        chk("mid_out_valid", out_valid, 1);

        // reset mid-operation
        rst = 1'b1; in0_valid = 1'b1;
        #1;
        chk("midrst_in0_ready", in0_ready, 0);
        chk("midrst_in1_ready", in1_ready, 0);
        step();
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sel", sel, 0);
        chk("midrst_d1", d1, 0);
        in0_data = 3'b110;
        #1;
        chk("postrst_in0_ready", in0_ready, 1);
        chk("postrst_in1_ready", in1_ready, 0);
        step();
        chk("postrst_sel", sel, 0);
        chk("postrst_d0", d0, 3'b110);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_rr_feeder.md
Name: mux_rr_feeder

Overview:
- Upstream stage for the parameterised 2:1 data mux (`d0`, `d1`, `sel`, `out_mux`).
- Arbitrates between two valid/ready source channels using round-robin.
- Registers the winning beat into the d0/d1 holding registers and drives the `sel` value the mux needs.
- Adds one registered pipeline stage with valid/ready toward the consumer, plus per-channel beat counters for debug.

Parameters:
- width_size, 2, MSB index of data paths; all data ports are width_size+1 bits (3 bits at default), matching the downstream mux.
- CNT_W, 8, width of the per-channel saturating beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in0_valid  input  1  channel 0 beat available.
- in0_data  input  width_size+1  channel 0 payload.
- in0_ready  output  1  channel 0 beat accepted this cycle.
- in1_valid  input  1  channel 1 beat available.
- in1_data  input  width_size+1  channel 1 payload.
- in1_ready  output  1  channel 1 beat accepted this cycle.
- d0  output  width_size+1  registered channel 0 data, to mux d0.
- d1  output  width_size+1  registered channel 1 data, to mux d1.
- sel  output  1  registered grant; 0 selects d0, 1 selects d1.
- out_valid  output  1  d0/d1/sel hold a beat not yet consumed.
- out_ready  input  1  consumer takes the mux output this cycle.
- cnt_clr  input  1  synchronous clear of both beat counters.
- cnt0  output  CNT_W  beats granted to channel 0, saturating.
- cnt1  output  CNT_W  beats granted to channel 1, saturating.

Behaviour:
- Reset (rst=1 at a rising edge):
  - out_valid=0, sel=0, d0=0, d1=0, cnt0=0, cnt1=0.
  - Internal last_grant=1, so channel 0 wins the first tie.
  - Any held beat is dropped.
  - in0_ready/in1_ready are 0 while rst is high.
- load = !out_valid || out_ready (combinational). The stage accepts a new beat only when empty or being drained in the same cycle.
- Grant (combinational, only when load=1):
  - Only in0_valid → grant 0.
  - Only in1_valid → grant 1.
  - Both valid → grant = !last_grant.
  - Neither valid → no grant.
- in0_ready = load && grant==0 && in0_valid; in1_ready = load && grant==1 && in1_valid. At most one ready is high per cycle. Ready never depends on its own channel's valid except through the grant.
- On a granted cycle, at the clock edge:
  - sel <= grant and last_grant <= grant.
  - Granted channel's data goes into d0 (grant 0) or d1 (grant 1); the other register holds its value.
  - out_valid <= 1.
- On load=1 with no grant: out_valid <= 0; sel, d0, d1 and last_grant hold.
- Stall (out_valid=1, out_ready=0): sel, d0, d1 and out_valid are frozen; both in*_ready=0.
- Latency: 1 cycle from input handshake to out_valid. Throughput: 1 beat per cycle when out_ready is held high.
- Fairness: with both channels continuously valid and out_ready=1, grants strictly alternate 0,1,0,1…
- Counters:
  - A channel's counter increments by 1 on each of its input handshakes and saturates at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle; result is 0.
  - rst clears both counters.
- Input data is sampled only on the handshake cycle. Changes on in*_data at any other time have no effect.

Test Plan:
- Reset then idle: rst high 2 cycles, all valids 0 → out_valid=0, sel=0, d0=d1=3'b000, cnt0=cnt1=0, in0_ready=in1_ready=0.
- Single channel: in0_valid=1, in0_data=3'b011, out_ready=1 → in0_ready=1 that cycle; next cycle d0=3'b011, sel=0, out_valid=1, cnt0=1.
- Tie and alternation: both valid, in0_data=3'b111, in1_data=3'b100, out_ready=1 for 4 cycles → sel sequence 0,1,0,1; d0=3'b111, d1=3'b100; cnt0=2, cnt1=2.
- Backpressure: beat held with out_ready=0 for 3 cycles while in1 toggles data → sel/d0/d1 unchanged, in0_ready=in1_ready=0; out_ready=1 then accepts the next beat the same cycle (out_valid stays 1).
- Saturation and clear: CNT_W=2, 5 channel-1 beats → cnt1=3; cnt_clr=1 coincident with a channel-1 grant → cnt1=0.
- Reset mid-operation: out_valid=1, sel=1, d1=3'b010, then rst pulse → out_valid=0, sel=0, d1=0; the next tie is granted to channel 0.
